uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Buffers 16-bit result words in a small FIFO and hands them, one byte at a
// time, to a UART transmitter using an enable/busy handshake. tx_busy comes
// from the baud-clock domain and is only used after a 2-flop synchronizer.
// Optional feature: define TX_SYNC_HEADER_EN to prefix every word with
// HDR_BYTE (header, low byte, high byte); otherwise each word is sent as
// low byte followed by high byte.
`timescale 1ns/1ps

module uart_tx_serializer #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_enable,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

`ifdef TX_SYNC_HEADER_EN
    // Byte index 0 is the header, 1 the low byte, 2 the high byte.
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    // Byte index 0 is the low byte, 1 the high byte.
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             busy_meta_reg;
    logic             busy_s_reg;
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [15:0]      word_reg;
    logic [1:0]       byte_idx_reg;
    logic [7:0]       tx_data_reg;
    logic [15:0]      head_word;
    logic             wr_en;
    logic             pop_en;

    // Byte of the current word selected by a byte index.
    function automatic logic [7:0] select_byte(input logic [15:0] word, input logic [1:0] idx);
`ifdef TX_SYNC_HEADER_EN
        case (idx)
            2'd0:    return HDR_BYTE;
            2'd1:    return word[7:0];
            default: return word[15:8];
        endcase
`else
        return (idx == 2'd0) ? word[7:0] : word[15:8];
`endif
    endfunction

`ifndef TX_SYNC_HEADER_EN
    // The header value has no role when headers are not sent.
    logic unused_hdr;
    assign unused_hdr = ^HDR_BYTE;
`endif

    assign in_ready   = (count_reg < DEPTH_CNT);
    assign wr_en      = in_valid && in_ready;
    assign pop_en     = (state_reg == S_POP);
    assign head_word  = mem[rd_ptr_reg];
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign tx_data    = tx_data_reg;
    // Decoded straight from the state register so reset drops it at once.
    assign tx_enable  = (state_reg == S_REQ);

    // Word storage: written on accept, contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer bringing tx_busy into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_reg <= 1'b0;
            busy_s_reg    <= 1'b0;
        end else begin
            busy_meta_reg <= tx_busy;
            busy_s_reg    <= busy_meta_reg;
        end
    end

    // Next-state logic for the byte handshake sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (count_reg != '0) state_next = S_POP;
            S_POP:   state_next = S_REQ;
            S_REQ:   if (busy_s_reg) state_next = S_ACK;
            S_ACK:   if (!busy_s_reg) state_next = S_DONE;
            S_DONE:  state_next = (byte_idx_reg == LAST_IDX) ? S_IDLE : S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus word/byte datapath; tx_data only changes when
    // leaving POP or DONE, so it holds through REQ, ACK and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            word_reg     <= '0;
            byte_idx_reg <= '0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_POP) begin
                word_reg     <= head_word;
                byte_idx_reg <= 2'd0;
                tx_data_reg  <= select_byte(head_word, 2'd0);
            end else if (state_reg == S_DONE && byte_idx_reg != LAST_IDX) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                tx_data_reg  <= select_byte(word_reg, byte_idx_reg + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a behavioural UART (enable -> busy for N
// cycles) plus an occupancy model (words accepted minus words started)
// checked every cycle, and scenario tasks checking the byte stream.
`timescale 1ns/1ps

module tb_uart_tx_serializer;

    localparam int         DEPTH = 8;
    localparam logic [7:0] HDR   = 8'hA5;
`ifdef TX_SYNC_HEADER_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 2;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [15:0]            in_data = 16'h0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [7:0]             tx_data;
    logic                   tx_enable;
    logic                   tx_busy = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DEPTH(DEPTH), .HDR_BYTE(HDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // ---------------- UART model and occupancy model ----------------
    int         cyc = 0;
    bit         uart_stall = 0;
    bit         busy_rand = 0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         acc_words = 0, started_words = 0, pos = 0;
    int         start_cnt = 0, last_start_cyc = 0, mon_prints = 0;
    bit         pend_acc = 0, ovf_pend = 0, ovf_exp = 0, prev_en = 0;
    logic [7:0] held_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int exp_cnt;
        if (!rst_n) begin
            busy_cnt = 0; tx_busy = 1'b0;
            acc_words = 0; started_words = 0; pos = 0;
            pend_acc = 0; ovf_pend = 0; ovf_exp = 0; prev_en = 0;
        end else begin
            if (busy_cnt != 0) begin
                busy_cnt--;
            end else if (tx_enable && !uart_stall) begin
                got_q.push_back(tx_data);
                busy_cnt = busy_rand ? int'($urandom_range(4, 12)) : busy_len;
            end
            tx_busy = (busy_cnt != 0);

            if (pend_acc) acc_words++;
            if (ovf_pend) ovf_exp = 1;
            if (tx_enable && prev_en) begin
                compared++;
                if (tx_data !== held_byte) begin
                    mismatched++;
                    if (mon_prints++ < 20) $display("FAIL mon_tx_data_stable got=%h exp=%h cyc=%0d", tx_data, held_byte, cyc);
                end
            end
            if (tx_enable && !prev_en) begin
                if (pos == 0) begin
                    started_words++; start_cnt++; last_start_cyc = cyc;
                end
                pos = (pos + 1) % BPW;
                held_byte = tx_data;
            end
            prev_en = tx_enable;

            exp_cnt = acc_words - started_words;
            compared++;
            if (int'(fifo_count) != exp_cnt) begin
                mismatched++;
                if (mon_prints++ < 20) $display("FAIL mon_fifo_count got=%0d exp=%0d cyc=%0d", fifo_count, exp_cnt, cyc);
            end
            compared++;
            if (in_ready !== (exp_cnt < DEPTH)) begin
                mismatched++;
                if (mon_prints++ < 20) $display("FAIL mon_in_ready got=%b exp=%b cyc=%0d", in_ready, (exp_cnt < DEPTH), cyc);
            end
            compared++;
            if (overflow !== ovf_exp) begin
                mismatched++;
                if (mon_prints++ < 20) $display("FAIL mon_overflow got=%b exp=%b cyc=%0d", overflow, ovf_exp, cyc);
            end
            pend_acc = in_valid && (exp_cnt < DEPTH);
            ovf_pend = in_valid && (exp_cnt >= DEPTH);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_expected(input logic [15:0] w);
`ifdef TX_SYNC_HEADER_EN
        exp_q.push_back(HDR);
`endif
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    // Offers one word once the FIFO has room; ok=0 if room never appears.
    task automatic send_word(input logic [15:0] w, output bit ok);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        ok = in_ready;
        if (ok) begin
            in_data = w; in_valid = 1'b1;
            push_expected(w);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        $display("send word=%h ok=%0d fifo_count=%0d", w, ok, fifo_count);
    endtask

    task automatic wait_drain(output bit ok);
        int t = 0;
        while (!(got_q.size() >= exp_q.size() && busy_cnt == 0 && !tx_enable) && t < 20000) begin
            @(negedge clk); #1; t++;
        end
        repeat (6) @(negedge clk);
        #1;
        ok = (t < 20000);
    endtask

    task automatic wait_enable(output bit ok);
        int t = 0;
        while (!tx_enable && t < 200) begin
            @(negedge clk); #1; t++;
        end
        ok = tx_enable;
    endtask

    task automatic wait_starts(input int target, output bit ok);
        int t = 0;
        while (start_cnt < target && t < 2000) begin
            @(negedge clk); #1; t++;
        end
        ok = (start_cnt >= target);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (tx_enable !== 1'b0 || tx_data !== 8'h00 || fifo_count !== '0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state got en=%b data=%h cnt=%0d ovf=%b rdy=%b exp 0/00/0/0/1", tx_enable, tx_data, fifo_count, overflow, in_ready);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (tx_enable !== 1'b0 || tx_data !== 8'h00 || fifo_count !== '0) begin
            mismatched++;
            $display("FAIL reset_release got en=%b data=%h cnt=%0d exp 0/00/0", tx_enable, tx_data, fifo_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        got_q.delete(); exp_q.delete(); busy_len = 10;
        send_word(16'h1234, ok);
        compared++;
        if (!ok || fifo_count !== 1) begin
            mismatched++; $display("FAIL single_count1 got=%0d exp=1 ok=%0d", fifo_count, ok);
        end
        wait_drain(ok);
        compared++;
        if (!ok || got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL single_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL single_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        compared++;
        if (fifo_count !== 0) begin
            mismatched++; $display("FAIL single_count0 got=%0d exp=0", fifo_count);
        end
        $display("test_single bytes=%0d", got_q.size());
    endtask

    task automatic test_stall();
        bit ok; logic [7:0] d; int bad = 0;
        got_q.delete(); exp_q.delete(); uart_stall = 1;
        send_word(16'($urandom), ok);
        wait_enable(ok);
        compared++;
        if (!ok || tx_data !== exp_q[0]) begin
            mismatched++; $display("FAIL stall_first_byte got=%h exp=%h en=%b", tx_data, exp_q[0], tx_enable);
        end
        d = tx_data;
        repeat (1000) begin
            @(negedge clk); #1;
            if (tx_enable !== 1'b1 || tx_data !== d) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++; $display("FAIL stall_hold got=%0d bad_cycles exp=0", bad);
        end
        uart_stall = 0;
        wait_drain(ok);
        compared++;
        if (!ok || got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_stall bytes=%0d", got_q.size());
    endtask

    task automatic test_simultaneous();
        bit ok; int base, s2, s3, p, t; logic [15:0] w;
        got_q.delete(); exp_q.delete(); busy_len = 10; uart_stall = 1;
        send_word(16'($urandom), ok);
        wait_enable(ok);
        repeat (3) send_word(16'($urandom), ok);
        compared++;
        if (fifo_count !== 3) begin
            mismatched++; $display("FAIL simul_fill got=%0d exp=3", fifo_count);
        end
        base = start_cnt; uart_stall = 0;
        wait_starts(base + 1, ok); s2 = last_start_cyc;
        send_word(16'($urandom), ok);
        wait_starts(base + 2, ok); s3 = last_start_cyc;
        send_word(16'($urandom), ok);
        p = s3 - s2; t = 0;
        while (cyc < s3 + p - 1 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        compared++;
        if (fifo_count !== 3 || cyc != s3 + p - 1) begin
            mismatched++; $display("FAIL simul_pre got=%0d cyc=%0d exp=3 cyc=%0d", fifo_count, cyc, s3 + p - 1);
        end
        w = 16'($urandom); in_data = w; in_valid = 1'b1; push_expected(w);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #1;
        compared++;
        if (fifo_count !== 3 || last_start_cyc != s3 + p) begin
            mismatched++; $display("FAIL simul_wr_pop got=%0d start=%0d exp=3 start=%0d", fifo_count, last_start_cyc, s3 + p);
        end
        wait_drain(ok);
        compared++;
        if (!ok || got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL simul_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL simul_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_simultaneous period=%0d bytes=%0d", p, got_q.size());
    endtask

    task automatic test_random_stream();
        bit ok;
        got_q.delete(); exp_q.delete(); busy_rand = 1;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_word(16'($urandom), ok);
        end
        wait_drain(ok);
        busy_rand = 0;
        compared++;
        if (!ok || got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_random_stream bytes=%0d", got_q.size());
    endtask

    task automatic test_overflow();
        bit ok; logic [15:0] w;
        got_q.delete(); exp_q.delete(); busy_len = 10; uart_stall = 1;
        send_word(16'($urandom), ok);
        wait_enable(ok);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = 16'($urandom); in_data = w; in_valid = 1'b1;
            if (i < DEPTH) push_expected(w);
            @(posedge clk); #1;
            $display("burst word=%h idx=%0d in_ready=%b fifo_count=%0d", w, i, in_ready, fifo_count);
            if (i == DEPTH - 1) begin
                compared++;
                if (in_ready !== 1'b0) begin
                    mismatched++; $display("FAIL ovf_ready got=%b exp=0", in_ready);
                end
            end
        end
        in_valid = 1'b0;
        compared++;
        if (fifo_count !== DEPTH || overflow !== 1'b1) begin
            mismatched++; $display("FAIL ovf_state got cnt=%0d ovf=%b exp cnt=%0d ovf=1", fifo_count, overflow, DEPTH);
        end
    endtask

    task automatic test_reset_mid_byte();
        bit ok; int t = 0;
        uart_stall = 0;
        while (got_q.size() < 2 * BPW && t < 2000) begin
            @(negedge clk); #1; t++;
        end
        repeat (5) @(negedge clk);
        #1;
        compared++;
        if (got_q.size() != 2 * BPW || tx_enable !== 1'b0 || fifo_count !== DEPTH - 1) begin
            mismatched++; $display("FAIL rstmid_pre got bytes=%0d en=%b cnt=%0d exp %0d/0/%0d", got_q.size(), tx_enable, fifo_count, 2 * BPW, DEPTH - 1);
        end
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        rst_n = 1'b0; #1;
        compared++;
        if (tx_enable !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0 || tx_data !== 8'h00) begin
            mismatched++; $display("FAIL rstmid_async got en=%b cnt=%0d ovf=%b data=%h exp 0/0/0/00", tx_enable, fifo_count, overflow, tx_data);
        end
        repeat (3) @(posedge clk);
        got_q.delete(); exp_q.delete();
        #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (tx_enable !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) begin
            mismatched++; $display("FAIL rstmid_release got en=%b cnt=%0d ovf=%b exp 0/0/0", tx_enable, fifo_count, overflow);
        end
        send_word(16'hBEEF, ok);
        wait_drain(ok);
        compared++;
        if (!ok || got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL rstmid_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL rstmid_after%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        $display("test_reset_mid_byte bytes_after=%0d", got_q.size());
    endtask

    task automatic test_reset_in_req();
        bit ok;
        got_q.delete(); exp_q.delete(); uart_stall = 1;
        send_word(16'h5AC3, ok);
        wait_enable(ok);
        rst_n = 1'b0; #1;
        compared++;
        if (!ok || tx_enable !== 1'b0 || tx_data !== 8'h00) begin
            mismatched++; $display("FAIL rstreq_async got en=%b data=%h ok=%0d exp 0/00", tx_enable, tx_data, ok);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; uart_stall = 0;
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (tx_enable !== 1'b0 || fifo_count !== '0) begin
            mismatched++; $display("FAIL rstreq_release got en=%b cnt=%0d exp 0/0", tx_enable, fifo_count);
        end
        $display("test_reset_in_req done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_simultaneous();
        test_random_stream();
        test_overflow();
        test_reset_mid_byte();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
